// File: rtl/uart_receive.sv
// rtl/uart_receive.sv - 8N1 UART receiver, oversampled on clk_in with mid-bit sampling
// Strobes each good byte on new_data_out and flags low stop bits on framing_error_out.

module uart_receive #(
  parameter int INPUT_CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE        = 9600
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       rx_wire_in,
  output logic [7:0] data_byte_out,
  output logic       new_data_out,
  output logic       framing_error_out,
  output logic       busy_out
);

  localparam int P  = INPUT_CLOCK_FREQ / BAUD_RATE;
  localparam int H  = P / 2;
  localparam int CW = $clog2(P) + 1;
  localparam logic [CW-1:0] H_LAST = CW'(H - 1);
  localparam logic [CW-1:0] P_LAST = CW'(P - 1);

  generate
    if (P < 4) begin : g_bad_ratio
      $error("uart_receive: INPUT_CLOCK_FREQ / BAUD_RATE must be at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic          rx_meta;
  logic          rx_sync;
  logic          rx_prev;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state             <= IDLE;
      rx_meta           <= 1'b1;
      rx_sync           <= 1'b1;
      rx_prev           <= 1'b1;
      cnt               <= '0;
      bit_idx           <= '0;
      shift_reg         <= '0;
      data_byte_out     <= 8'h00;
      new_data_out      <= 1'b0;
      framing_error_out <= 1'b0;
      busy_out          <= 1'b0;
    end else begin
      rx_meta           <= rx_wire_in;
      rx_sync           <= rx_meta;
      rx_prev           <= rx_sync;
      new_data_out      <= 1'b0;
      framing_error_out <= 1'b0;

      case (state)
        IDLE: begin
          busy_out <= 1'b0;
          // Only a falling edge starts a frame, so a line stuck low after a bad stop stays quiet.
          if (rx_prev && !rx_sync) begin
            state    <= START;
            cnt      <= '0;
            busy_out <= 1'b1;
          end
        end

        START: begin
          if (cnt == H_LAST) begin
            cnt <= '0;
            if (!rx_sync) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state    <= IDLE;
              busy_out <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DATA: begin
          if (cnt == P_LAST) begin
            cnt       <= '0;
            shift_reg <= {rx_sync, shift_reg[7:1]};
            bit_idx   <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        STOP: begin
          if (cnt == P_LAST) begin
            cnt      <= '0;
            state    <= IDLE;
            busy_out <= 1'b0;
            if (rx_sync) begin
              data_byte_out <= shift_reg;
              new_data_out  <= 1'b1;
            end else begin
              framing_error_out <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          state    <= IDLE;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receive.sv
// tb/tb_uart_receive.sv - directed self-checking bench for uart_receive at P=10, H=5
// Frame offsets j count negedges from the one that drives the start bit; C0 corresponds to j=2.

module tb_uart_receive;

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  logic       rx_wire_in = 1'b1;
  logic [7:0] data_byte_out;
  logic       new_data_out;
  logic       framing_error_out;
  logic       busy_out;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int         ev_nd_cnt, ev_fe_cnt, ev_nd_j, ev_fe_j;
  int         ev_busy_first, ev_busy_last, ev_busy_cnt, ev_nd_cyc;
  logic [7:0] ev_data;

  uart_receive #(
    .INPUT_CLOCK_FREQ(1_000_000),
    .BAUD_RATE       (100_000)
  ) dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .rx_wire_in       (rx_wire_in),
    .data_byte_out    (data_byte_out),
    .new_data_out     (new_data_out),
    .framing_error_out(framing_error_out),
    .busy_out         (busy_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic clear_ev();
    ev_nd_cnt = 0; ev_fe_cnt = 0; ev_nd_j = -1; ev_fe_j = -1;
    ev_busy_first = -1; ev_busy_last = -1; ev_busy_cnt = 0; ev_nd_cyc = -1;
    ev_data = 8'h00;
  endtask

  task automatic observe(input int j);
    if (new_data_out) begin
      ev_nd_cnt++; ev_nd_j = j; ev_data = data_byte_out; ev_nd_cyc = cyc;
    end
    if (framing_error_out) begin
      ev_fe_cnt++; ev_fe_j = j;
    end
    if (busy_out) begin
      if (ev_busy_first < 0) ev_busy_first = j;
      ev_busy_last = j;
      ev_busy_cnt++;
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input logic stop, input int j);
    if (j < 10) return 1'b0;
    if (j < 90) return b[j / 10 - 1];
    return stop;
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stop);
    clear_ev();
    for (int j = 0; j < 100; j++) begin
      @(negedge clk_in);
      rx_wire_in = frame_bit(b, stop, j);
      observe(j);
    end
  endtask

  task automatic drive_line(input logic v, input int n);
    clear_ev();
    for (int j = 0; j < n; j++) begin
      @(negedge clk_in);
      rx_wire_in = v;
      observe(j);
    end
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    rx_wire_in = 1'b1;
    repeat (3) @(negedge clk_in);
    checks++; if (data_byte_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h expected 00", data_byte_out); end
    checks++; if (new_data_out !== 1'b0) begin errors++; $display("FAIL reset_new_data: got %0b expected 0", new_data_out); end
    checks++; if (framing_error_out !== 1'b0) begin errors++; $display("FAIL reset_framing: got %0b expected 0", framing_error_out); end
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy_out); end
    rst_n_in = 1'b1;
    drive_line(1'b1, 10);
    checks++; if (ev_busy_cnt !== 0) begin errors++; $display("FAIL reset_idle_quiet: got %0d busy cycles expected 0", ev_busy_cnt); end
  endtask

  task automatic test_good_frame();
    send_frame(8'hA5, 1'b1);
    checks++; if (ev_nd_cnt !== 1) begin errors++; $display("FAIL good_nd_count: got %0d expected 1", ev_nd_cnt); end
    checks++; if (ev_nd_j !== 98) begin errors++; $display("FAIL good_nd_time: got j=%0d expected j=98", ev_nd_j); end
    checks++; if (ev_data !== 8'hA5) begin errors++; $display("FAIL good_data: got %0h expected a5", ev_data); end
    checks++; if (ev_fe_cnt !== 0) begin errors++; $display("FAIL good_fe_count: got %0d expected 0", ev_fe_cnt); end
    checks++; if (ev_busy_first !== 3) begin errors++; $display("FAIL good_busy_rise: got j=%0d expected j=3", ev_busy_first); end
    checks++; if (ev_busy_last !== 97) begin errors++; $display("FAIL good_busy_fall: got j=%0d expected j=97", ev_busy_last); end
    checks++; if (ev_busy_cnt !== 95) begin errors++; $display("FAIL good_busy_len: got %0d expected 95", ev_busy_cnt); end
    drive_line(1'b1, 5);
    checks++; if (data_byte_out !== 8'hA5) begin errors++; $display("FAIL good_data_hold: got %0h expected a5", data_byte_out); end
  endtask

  task automatic test_back_to_back();
    int first_cyc;
    send_frame(8'h00, 1'b1);
    first_cyc = ev_nd_cyc;
    checks++; if (ev_nd_cnt !== 1 || ev_data !== 8'h00) begin errors++; $display("FAIL b2b_first: got cnt=%0d data=%0h expected cnt=1 data=00", ev_nd_cnt, ev_data); end
    send_frame(8'hFF, 1'b1);
    checks++; if (ev_nd_cnt !== 1 || ev_data !== 8'hFF) begin errors++; $display("FAIL b2b_second: got cnt=%0d data=%0h expected cnt=1 data=ff", ev_nd_cnt, ev_data); end
    checks++; if (ev_nd_cyc - first_cyc !== 100) begin errors++; $display("FAIL b2b_spacing: got %0d expected 100", ev_nd_cyc - first_cyc); end
    drive_line(1'b1, 10);
  endtask

  task automatic test_glitch();
    clear_ev();
    for (int j = 0; j < 30; j++) begin
      @(negedge clk_in);
      rx_wire_in = (j < 2) ? 1'b0 : 1'b1;
      observe(j);
    end
    checks++; if (ev_busy_first !== 3) begin errors++; $display("FAIL glitch_busy_rise: got j=%0d expected j=3", ev_busy_first); end
    checks++; if (ev_busy_last !== 7) begin errors++; $display("FAIL glitch_busy_fall: got j=%0d expected j=7", ev_busy_last); end
    checks++; if (ev_nd_cnt !== 0 || ev_fe_cnt !== 0) begin errors++; $display("FAIL glitch_pulses: got nd=%0d fe=%0d expected 0 0", ev_nd_cnt, ev_fe_cnt); end
  endtask

  task automatic test_framing_error();
    send_frame(8'h11, 1'b1);
    checks++; if (ev_data !== 8'h11) begin errors++; $display("FAIL fe_prior_data: got %0h expected 11", ev_data); end
    send_frame(8'h3C, 1'b0);
    checks++; if (ev_fe_cnt !== 1 || ev_fe_j !== 98) begin errors++; $display("FAIL fe_pulse: got cnt=%0d j=%0d expected cnt=1 j=98", ev_fe_cnt, ev_fe_j); end
    checks++; if (ev_nd_cnt !== 0) begin errors++; $display("FAIL fe_no_nd: got %0d expected 0", ev_nd_cnt); end
    checks++; if (data_byte_out !== 8'h11) begin errors++; $display("FAIL fe_data_hold: got %0h expected 11", data_byte_out); end
    drive_line(1'b0, 30);
    checks++; if (ev_busy_cnt !== 0 || ev_nd_cnt !== 0 || ev_fe_cnt !== 0) begin errors++; $display("FAIL fe_break_quiet: got busy=%0d nd=%0d fe=%0d expected 0 0 0", ev_busy_cnt, ev_nd_cnt, ev_fe_cnt); end
    drive_line(1'b1, 5);
    send_frame(8'h81, 1'b1);
    checks++; if (ev_nd_cnt !== 1 || ev_data !== 8'h81) begin errors++; $display("FAIL fe_recover: got cnt=%0d data=%0h expected cnt=1 data=81", ev_nd_cnt, ev_data); end
    drive_line(1'b1, 5);
  endtask

  task automatic test_mid_frame_reset();
    for (int j = 0; j < 45; j++) begin
      @(negedge clk_in);
      rx_wire_in = frame_bit(8'h5A, 1'b1, j);
    end
    checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL rst_busy_before: got %0b expected 1", busy_out); end
    rst_n_in = 1'b0;
    #1;
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b expected 0", busy_out); end
    checks++; if (data_byte_out !== 8'h00) begin errors++; $display("FAIL rst_data: got %0h expected 00", data_byte_out); end
    checks++; if (new_data_out !== 1'b0 || framing_error_out !== 1'b0) begin errors++; $display("FAIL rst_pulses: got nd=%0b fe=%0b expected 0 0", new_data_out, framing_error_out); end
    drive_line(1'b1, 4);
    rst_n_in = 1'b1;
    drive_line(1'b1, 60);
    checks++; if (ev_busy_cnt !== 0 || ev_nd_cnt !== 0 || ev_fe_cnt !== 0) begin errors++; $display("FAIL rst_after_quiet: got busy=%0d nd=%0d fe=%0d expected 0 0 0", ev_busy_cnt, ev_nd_cnt, ev_fe_cnt); end
    send_frame(8'h5A, 1'b1);
    checks++; if (ev_nd_cnt !== 1 || ev_data !== 8'h5A || ev_nd_j !== 98) begin errors++; $display("FAIL rst_then_frame: got cnt=%0d data=%0h j=%0d expected 1 5a 98", ev_nd_cnt, ev_data, ev_nd_j); end
    drive_line(1'b1, 5);
  endtask

  task automatic test_stream();
    int total_nd = 0;
    int total_fe = 0;
    for (int i = 0; i < 256; i++) begin
      send_frame(i[7:0], 1'b1);
      total_nd += ev_nd_cnt;
      total_fe += ev_fe_cnt;
      checks++; if (ev_nd_cnt !== 1 || ev_data !== i[7:0]) begin errors++; $display("FAIL stream_byte_%0d: got cnt=%0d data=%0h expected cnt=1 data=%0h", i, ev_nd_cnt, ev_data, i[7:0]); end
    end
    checks++; if (total_nd !== 256) begin errors++; $display("FAIL stream_total: got %0d expected 256", total_nd); end
    checks++; if (total_fe !== 0) begin errors++; $display("FAIL stream_fe: got %0d expected 0", total_fe); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_back_to_back();
    test_glitch();
    test_framing_error();
    test_mid_frame_reset();
    test_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_receive.md
# uart_receive

Serial-to-parallel UART receiver: 8 data bits, no parity, 1 stop bit, LSB first, idle-high line. Recovers bytes from an asynchronous serial line by oversampling on the system clock and centring each sample in its bit period. Serves as the receive end of the board's UART link, pairing with `uart_transmit` at identical parameters. Delivers each byte as a one-cycle strobe, and flags frames whose stop bit is low.

## Interface
- `INPUT_CLOCK_FREQ`, default 100_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 9600: line bit rate in bit/s.
- `clk_in`  input  1: system clock, rising-edge.
- `rst_n_in`  input  1: asynchronous, active-low reset. One clock domain; no other clocks.
- `rx_wire_in`  input  1: serial line, asynchronous to `clk_in`.
- `data_byte_out`  output  8: last correctly framed byte; holds its value until the next good frame.
- `new_data_out`  output  1: one-cycle pulse; `data_byte_out` is valid and updated in this cycle.
- `framing_error_out`  output  1: one-cycle pulse when the sampled stop bit is 0.
- `busy_out`  output  1: high from start-bit detection until return to IDLE.

## Operation
- Derived constants:
  - P = floor(INPUT_CLOCK_FREQ / BAUD_RATE).
  - H = floor(P/2).
  - The bit-rate counter is $clog2(P)+1 bits wide.
  - P ≥ 4 is required; enforce it by elaboration-time assertion.
- Input conditioning:
  - `rx_wire_in` passes through a 2-flop synchronizer (both flops reset to 1), giving `rx_sync`.
  - One further flop `rx_prev` (reset 1) supports falling-edge detection.
- FSM states: IDLE, START, DATA, STOP.
  - **IDLE:** `busy_out` = 0. If `rx_prev`=1 and `rx_sync`=0, go to START, clear the counter, and raise `busy_out`.
  - **START:** the counter increments each cycle. When it reaches H-1, sample `rx_sync`.
    - 0: go to DATA, clear the counter and the bit index.
    - 1: glitch; go to IDLE with no pulses.
  - **DATA:** when the counter reaches P-1, sample `rx_sync` into the shift register MSB, right-shifting so bit 0 arrives first. Clear the counter and increment the bit index. After the 8th sample, go to STOP.
  - **STOP:** when the counter reaches P-1, sample `rx_sync`.
    - 1: load `data_byte_out` from the shift register and pulse `new_data_out`.
    - 0: pulse `framing_error_out` and leave `data_byte_out` unchanged.
    - Either way, go to IDLE.
- Break or low-stop recovery: a new start requires a falling edge. A line held low after a framing error starts no frame until it has returned high for at least one synced cycle.
- Outputs `new_data_out` and `framing_error_out` are registered and mutually exclusive.
- Reset (`rst_n_in` low, any time, including mid-frame):
  - Immediately forces IDLE.
  - Sets `data_byte_out`=0x00, `new_data_out`=0, `framing_error_out`=0, `busy_out`=0.
  - Sets the synchronizer, `rx_prev`, counter, bit index and shift register to 1/0 defaults.
- Reset release is used synchronously. The first edge detection occurs no earlier than 2 cycles after release.

## Timing
- Let cycle C0 be the first cycle in which `rx_sync`=0 while `rx_prev`=1. C0 is 2–3 clocks after the line falls, because of synchronizer latency.
- Event schedule relative to C0:
  - `busy_out` rises at C0+1.
  - Start-bit sample at C0+H.
  - Data bit i (i=0..7) sampled at C0+H+(i+1)·P.
  - Stop bit sampled at C0+H+9·P.
  - `new_data_out` or `framing_error_out` high for exactly the cycle C0+H+9·P+1.
  - `busy_out` falls in that same cycle.
- Back-to-back frames: the FSM is in IDLE by the midpoint of the stop bit. It therefore catches a start bit that begins immediately after a full-length stop bit.
- Tolerance: a transmitter baud error of ±2% must still decode, because sampling stays within a bit cell over 10 bits.

## Test plan
All scenarios use `INPUT_CLOCK_FREQ`=1_000_000 and `BAUD_RATE`=100_000 (P=10, H=5), and drive `rx_wire_in` at 10 clocks per bit.
- **Good frame:** drive frame 0xA5 with stop=1 → one `new_data_out` pulse at C0+96, `data_byte_out`=0xA5, `framing_error_out` never high, `busy_out` high for cycles C0+1..C0+95.
- **Back-to-back:** drive frames 0x00 then 0xFF with no idle gap → two pulses, 100 cycles apart, carrying 0x00 then 0xFF.
- **Glitch rejection:** drive the line low for 2 cycles in idle → `busy_out` pulses, then returns to 0 by C0+6; no `new_data_out` or `framing_error_out`.
- **Framing error and recovery:**
  - Drive frame 0x3C with stop=0, after a prior good 0x11 → `framing_error_out` pulse; `data_byte_out` stays 0x11.
  - Hold the line low for 30 cycles → no activity.
  - Release high, then send 0x81 → `new_data_out` with 0x81.
- **Mid-frame reset:** assert `rst_n_in` low during data bit 3 → all outputs go to 0 within the same cycle, with no pulse afterwards. After release, a 0x5A frame is received correctly.
- **Loopback:** connect `uart_transmit` at the same parameters to this block and send 256 sequential bytes → 256 pulses, data matching in order, zero framing errors.
